glyph_row_serializer: RTL and testbench

GLYPH_ROW_SERIALIZER -- requirements
Module: glyph_row_serializer

---
 rtl/glyph_pkg.sv | 6 +
 rtl/glyph_shift_reg.sv | 17 +
 rtl/glyph_row_serializer.sv | 74 +++++++
 tb/tb_glyph_row_serializer.sv | 118 +++++++++++
 4 files changed

// File: rtl/glyph_pkg.sv
// glyph_pkg: shared defaults and FSM state type for the glyph row serializer
package glyph_pkg;
  localparam int GLYPH_W_DEF = 5;
  localparam int ROW_W_DEF = 3;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_t;
endpackage

// File: rtl/glyph_shift_reg.sv
// glyph_shift_reg: parallel-load, shift-left-with-zero-fill register exposing its MSB
module glyph_shift_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic         msb
);
  logic [W-1:0] q;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else q <= load ? d : shift_en ? q << 1 : q;
  assign msb = q[W-1];
endmodule

// File: rtl/glyph_row_serializer.sv
// glyph_row_serializer: renders one glyph ROM row as pixel ticks, MSB first.
// Define GLYPH_GAP_EN to append one blank column after each row.
module glyph_row_serializer
  import glyph_pkg::*;
#(
  parameter int GLYPH_W = GLYPH_W_DEF,
  parameter int ROW_W   = ROW_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               start,
  input  logic [ROW_W-1:0]   row_sel,
  output logic [ROW_W-1:0]   rom_row,
  input  logic [GLYPH_W-1:0] rom_code,
  output logic               pixel_on,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(GLYPH_W + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic msb, last;
  assign last = cnt == CW'(GLYPH_W - 1);
  assign busy = state != IDLE;
  glyph_shift_reg #(.W(GLYPH_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (state == FETCH),
    .shift_en (state == SHIFT && pix_en),
    .d        (rom_code),
    .msb      (msb)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      rom_row  <= '0;
      cnt      <= '0;
      pixel_on <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            rom_row <= row_sel;
            state   <= FETCH;
          end
        FETCH: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT:
          if (pix_en) begin
            cnt <= cnt + CW'(1);
            if (last) begin
`ifdef GLYPH_GAP_EN
              state <= GAP;
`else
              state <= IDLE;
              done  <= 1'b1;
`endif
            end
          end
        GAP:
          if (pix_en) begin
            state <= IDLE;
            done  <= 1'b1;
          end
      endcase
      // Outside SHIFT every tick blanks the pixel, so no stale glyph bit leaks out
      if (pix_en) pixel_on <= state == SHIFT && msb;
    end
endmodule

// File: tb/tb_glyph_row_serializer.sv
// tb_glyph_row_serializer: directed self-checking bench for glyph_row_serializer
module tb_glyph_row_serializer;
`ifdef GLYPH_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset, pix_en, start;
  logic [2:0] row_sel, rom_row;
  logic [4:0] rom_code;
  logic       pixel_on, busy, done;
  logic [4:0] rom [8];
  int n_chk = 0, n_pass = 0;
  assign rom_code = rom[rom_row];
  always #5 clk = ~clk;
  glyph_row_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .pix_en   (pix_en),
    .start    (start),
    .row_sel  (row_sel),
    .rom_row  (rom_row),
    .rom_code (rom_code),
    .pixel_on (pixel_on),
    .busy     (busy),
    .done     (done)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input logic pe, input logic st, input logic [2:0] rs);
    pix_en = pe;
    start = st;
    row_sel = rs;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    start = 1'b0;
  endtask
  task automatic render(input logic [2:0] row, input logic [4:0] code, input int per,
                        input logic early, input logic inj);
    cyc(early, 1'b1, row);
    check("rom_row", rom_row, row);
    check("busy_fetch", busy, 1'b1);
    if (early) check("start_tick_blank", pixel_on, 1'b0);
    cyc(early, 1'b0, 3'd0);
    if (early) check("fetch_tick_blank", pixel_on, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, inj && i == 2, 3'd3);
      check("pixel", pixel_on, code[4-i]);
      check("rom_row_stable", rom_row, row);
      if (i < 4 || GAP_ON) begin
        check("done_early", done, 1'b0);
        check("busy_shift", busy, 1'b1);
        for (int j = 1; j < per; j++) begin
          cyc(1'b0, 1'b0, 3'd0);
          check("pixel_hold", pixel_on, code[4-i]);
          check("busy_hold", busy, 1'b1);
        end
      end
    end
    if (GAP_ON) begin
      cyc(1'b1, 1'b0, 3'd0);
      check("gap_pixel", pixel_on, 1'b0);
    end
    check("done", done, 1'b1);
    check("busy_end", busy, 1'b0);
    cyc(1'b0, 1'b0, 3'd0);
    check("done_once", done, 1'b0);
    check("no_queue", busy, 1'b0);
  endtask
  initial begin
    rom[0] = 5'b00000; rom[1] = 5'b11111; rom[2] = 5'b10101; rom[3] = 5'b00000;
    rom[4] = 5'b10110; rom[5] = 5'b01000; rom[6] = 5'b00001; rom[7] = 5'b11011;
    reset = 1'b1;
    pix_en = 1'b0;
    start = 1'b0;
    row_sel = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_row", rom_row, 3'd0);
    check("rst_pixel", pixel_on, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 3'd0);
    render(3'd1, 5'b11111, 1, 1'b0, 1'b0);
    render(3'd2, 5'b10101, 4, 1'b0, 1'b0);
    render(3'd1, 5'b11111, 1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 3'd1);
    cyc(1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 3'd0);
    check("pre_abort_pixel", pixel_on, 1'b1);
    pix_en = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("abort_pixel", pixel_on, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rom_row", rom_row, 3'd0);
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", done, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 3'd0);
    check("post_abort_done", done, 1'b0);
    render(3'd1, 5'b11111, 1, 1'b0, 1'b0);
    render(3'd4, 5'b10110, 1, 1'b1, 1'b0);
    render(3'd3, 5'b00000, 1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
